bcd_rtc: RTL and testbench

//   Parametrised BCD time-of-day counter with a clock-cycle prescaler, synchronous time load,

---
 rtl/bcd_rtc.sv | 110 +++++++++++
 tb/tb_bcd_rtc.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/bcd_rtc.sv
// bcd_rtc: BCD time-of-day counter with prescaler, time/alarm load, alarm pulse and 12h/24h display
module bcd_rtc #(
    parameter int TICK_DIV = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        en_i,
    input  logic        mode_12h_i,
    input  logic        set_i,
    input  logic [23:0] set_time_i,
    input  logic        alarm_set_i,
    input  logic [23:0] alarm_time_i,
    input  logic        alarm_en_i,
    output logic [3:0]  hours_high_o,
    output logic [3:0]  hours_low_o,
    output logic [3:0]  minutes_high_o,
    output logic [3:0]  minutes_low_o,
    output logic [3:0]  seconds_high_o,
    output logic [3:0]  seconds_low_o,
    output logic        pm_o,
    output logic        tick_o,
    output logic        alarm_o,
    output logic        set_err_o
);
    localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
    logic [CW-1:0] cnt;
    logic [23:0]   tm, alm, tm_inc;
    logic          tick, set_ok, alm_ok, c_sl, c_sh, c_ml, c_mh;
    function automatic logic valid(input logic [23:0] t);
        return t[23:20] <= 4'd2 && t[19:16] <= 4'd9 && t[15:12] <= 4'd5 &&
               t[11:8] <= 4'd9 && t[7:4] <= 4'd5 && t[3:0] <= 4'd9 &&
               !(t[23:20] == 4'd2 && t[19:16] > 4'd3);
    endfunction
    assign tick   = en_i && cnt == LAST;
    assign set_ok = valid(set_time_i);
    assign alm_ok = valid(alarm_time_i);
    assign c_sl   = tm[3:0] == 4'd9;
    assign c_sh   = c_sl && tm[7:4] == 4'd5;
    assign c_ml   = c_sh && tm[11:8] == 4'd9;
    assign c_mh   = c_ml && tm[15:12] == 4'd5;
    // Next time value one second ahead, rippling BCD carries digit by digit
    always_comb begin
        tm_inc[3:0]   = c_sl ? 4'd0 : tm[3:0] + 4'd1;
        tm_inc[7:4]   = c_sl ? (c_sh ? 4'd0 : tm[7:4] + 4'd1) : tm[7:4];
        tm_inc[11:8]  = c_sh ? (c_ml ? 4'd0 : tm[11:8] + 4'd1) : tm[11:8];
        tm_inc[15:12] = c_ml ? (c_mh ? 4'd0 : tm[15:12] + 4'd1) : tm[15:12];
        tm_inc[23:16] = !c_mh ? tm[23:16] :
                        tm[23:16] == 8'h23 ? 8'h00 :
                        tm[19:16] == 4'd9 ? {tm[23:20] + 4'd1, 4'd0} :
                        {tm[23:20], tm[19:16] + 4'd1};
    end
    // Prescaler and time registers; a load wins over a coincident tick
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt     <= '0;
            tm      <= '0;
            tick_o  <= 1'b0;
            alarm_o <= 1'b0;
        end else begin
            tick_o  <= tick && !set_i;
            alarm_o <= tick && !set_i && alarm_en_i && tm_inc == alm;
            if (set_i) begin
                if (set_ok) begin
                    tm  <= set_time_i;
                    cnt <= '0;
                end
            end else if (en_i) begin
                cnt <= tick ? '0 : cnt + 1'b1;
                if (tick) tm <= tm_inc;
            end
        end
    end
    // Alarm register and invalid-load flag
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            alm       <= '0;
            set_err_o <= 1'b0;
        end else begin
            set_err_o <= (set_i && !set_ok) || (alarm_set_i && !alm_ok);
            if (alarm_set_i && alm_ok) alm <= alarm_time_i;
        end
    end
    // Hours display: 24h passthrough, or 12h remap with pm flag
    always_comb begin
        hours_high_o = tm[23:20];
        hours_low_o  = tm[19:16];
        pm_o         = 1'b0;
        if (mode_12h_i) begin
            pm_o = tm[23:20] == 4'd2 || (tm[23:20] == 4'd1 && tm[19:16] >= 4'd2);
            if (tm[23:16] == 8'h00) begin
                hours_high_o = 4'd1;
                hours_low_o  = 4'd2;
            end else if (tm[23:20] == 4'd1 && tm[19:16] >= 4'd3) begin
                hours_high_o = 4'd0;
                hours_low_o  = tm[19:16] - 4'd2;
            end else if (tm[23:20] == 4'd2 && tm[19:16] <= 4'd1) begin
                hours_high_o = 4'd0;
                hours_low_o  = tm[19:16] + 4'd8;
            end else if (tm[23:20] == 4'd2) begin
                hours_high_o = 4'd1;
                hours_low_o  = tm[19:16] - 4'd2;
            end
        end
    end
    assign minutes_high_o = tm[15:12];
    assign minutes_low_o  = tm[11:8];
    assign seconds_high_o = tm[7:4];
    assign seconds_low_o  = tm[3:0];
endmodule

// File: tb/tb_bcd_rtc.sv
// tb_bcd_rtc: directed checks of bcd_rtc with TICK_DIV=4
module tb_bcd_rtc;
    logic        clk_i = 1'b0, rst_ni = 1'b0, en_i = 1'b0, mode_12h_i = 1'b0;
    logic        set_i = 1'b0, alarm_set_i = 1'b0, alarm_en_i = 1'b0;
    logic [23:0] set_time_i = '0, alarm_time_i = '0;
    logic [3:0]  hh_h, hh_l, mm_h, mm_l, ss_h, ss_l;
    logic        pm_o, tick_o, alarm_o, set_err_o;
    logic [23:0] disp;
    int          checks = 0, errors = 0;
    bcd_rtc #(.TICK_DIV(4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i), .mode_12h_i(mode_12h_i),
        .set_i(set_i), .set_time_i(set_time_i), .alarm_set_i(alarm_set_i),
        .alarm_time_i(alarm_time_i), .alarm_en_i(alarm_en_i),
        .hours_high_o(hh_h), .hours_low_o(hh_l), .minutes_high_o(mm_h),
        .minutes_low_o(mm_l), .seconds_high_o(ss_h), .seconds_low_o(ss_l),
        .pm_o(pm_o), .tick_o(tick_o), .alarm_o(alarm_o), .set_err_o(set_err_o)
    );
    assign disp = {hh_h, hh_l, mm_h, mm_l, ss_h, ss_l};
    always #5 clk_i = ~clk_i;
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask
    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic load(input logic [23:0] t);
        set_i = 1'b1;
        set_time_i = t;
        step();
        set_i = 1'b0;
    endtask
    task automatic tick_once();
        en_i = 1'b1;
        repeat (4) step();
        en_i = 1'b0;
    endtask
    initial begin
        repeat (2) step();
        chk("rst_time", disp, 24'h000000);
        chk("rst_flags", {21'd0, tick_o, alarm_o, set_err_o}, 24'd0);
        mode_12h_i = 1'b1;
        #1;
        chk("rst_12h", disp, 24'h120000);
        chk("rst_12h_pm", {23'd0, pm_o}, 24'd0);
        mode_12h_i = 1'b0;
        rst_ni = 1'b1;
        // T1 prescaler
        en_i = 1'b1;
        repeat (3) step();
        chk("t1_pre_tick", {23'd0, tick_o}, 24'd0);
        chk("t1_pre_time", disp, 24'h000000);
        step();
        chk("t1_tick1", {23'd0, tick_o}, 24'd1);
        chk("t1_sec1", disp, 24'h000001);
        step();
        chk("t1_tick_pulse", {23'd0, tick_o}, 24'd0);
        repeat (3) step();
        chk("t1_tick2", {23'd0, tick_o}, 24'd1);
        chk("t1_sec2", disp, 24'h000002);
        en_i = 1'b0;
        repeat (10) step();
        chk("t1_hold", disp, 24'h000002);
        chk("t1_hold_tick", {23'd0, tick_o}, 24'd0);
        // T2 carries
        load(24'h235959);
        chk("t2_load", disp, 24'h235959);
        tick_once();
        chk("t2_wrap", disp, 24'h000000);
        chk("t2_wrap_tick", {23'd0, tick_o}, 24'd1);
        load(24'h095959);
        tick_once();
        chk("t2_hour_carry", disp, 24'h100000);
        load(24'h000559);
        tick_once();
        chk("t2_min_carry", disp, 24'h000600);
        // T3 12h display
        mode_12h_i = 1'b1;
        load(24'h003000);
        chk("t3_0030", disp, 24'h123000);
        chk("t3_0030_pm", {23'd0, pm_o}, 24'd0);
        load(24'h120000);
        chk("t3_1200", disp, 24'h120000);
        chk("t3_1200_pm", {23'd0, pm_o}, 24'd1);
        load(24'h210000);
        chk("t3_2100", disp, 24'h090000);
        load(24'h230000);
        chk("t3_2300", disp, 24'h110000);
        load(24'h130500);
        chk("t3_1305", disp, 24'h010500);
        chk("t3_1305_pm", {23'd0, pm_o}, 24'd1);
        mode_12h_i = 1'b0;
        #1;
        chk("t3_back_24h", disp, 24'h130500);
        chk("t3_back_pm", {23'd0, pm_o}, 24'd0);
        // T4 invalid loads
        load(24'h240000);
        chk("t4_24h_err", {23'd0, set_err_o}, 24'd1);
        chk("t4_24h_time", disp, 24'h130500);
        step();
        chk("t4_err_pulse", {23'd0, set_err_o}, 24'd0);
        load(24'h126000);
        chk("t4_60m_err", {23'd0, set_err_o}, 24'd1);
        chk("t4_60m_time", disp, 24'h130500);
        load(24'h0A0000);
        chk("t4_hex_err", {23'd0, set_err_o}, 24'd1);
        chk("t4_hex_time", disp, 24'h130500);
        alarm_set_i = 1'b1;
        alarm_time_i = 24'h006000;
        step();
        alarm_set_i = 1'b0;
        chk("t4_alarm_err", {23'd0, set_err_o}, 24'd1);
        // T5 alarm
        alarm_set_i = 1'b1;
        alarm_time_i = 24'h000010;
        step();
        alarm_set_i = 1'b0;
        chk("t5_alarm_ok", {23'd0, set_err_o}, 24'd0);
        load(24'h000000);
        alarm_en_i = 1'b1;
        en_i = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            repeat (4) step();
            chk($sformatf("t5_tick%0d", i), {22'd0, tick_o, alarm_o}, {22'd0, 1'b1, i == 10});
        end
        step();
        chk("t5_alarm_pulse", {23'd0, alarm_o}, 24'd0);
        en_i = 1'b0;
        alarm_en_i = 1'b0;
        load(24'h000009);
        tick_once();
        chk("t5_dis_time", disp, 24'h000010);
        chk("t5_disabled", {22'd0, tick_o, alarm_o}, 24'd2);
        alarm_en_i = 1'b1;
        load(24'h000010);
        chk("t5_load_onto", {23'd0, alarm_o}, 24'd0);
        step();
        chk("t5_load_onto2", {23'd0, alarm_o}, 24'd0);
        alarm_en_i = 1'b0;
        // T6 load beats tick, async reset
        en_i = 1'b1;
        repeat (3) step();
        set_i = 1'b1;
        set_time_i = 24'h000200;
        step();
        set_i = 1'b0;
        en_i = 1'b0;
        chk("t6_load_wins", disp, 24'h000200);
        chk("t6_no_tick", {22'd0, tick_o, alarm_o}, 24'd0);
        en_i = 1'b1;
        repeat (3) step();
        chk("t6_pre_zero", {23'd0, tick_o}, 24'd0);
        step();
        chk("t6_pre_reset", {23'd0, tick_o}, 24'd1);
        chk("t6_time", disp, 24'h000201);
        #1 rst_ni = 1'b0;
        #1;
        chk("t6_async_time", disp, 24'h000000);
        chk("t6_async_tick", {23'd0, tick_o}, 24'd0);
        step();
        rst_ni = 1'b1;
        en_i = 1'b0;
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
